// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS ID/EX stage: ALU selection codes,
// ALUOp encodings, R-type funct values and the EX control bundle.
package mips_pkg;

  // ALU selection codes driven onto selectionLines
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // ALUOp encodings produced by the main decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  // R-type funct fields the ALU understands
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // Control carried from ID into EX
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       illegal;
    logic [3:0] alu_sel;
  } ex_ctrl_t;

  // A bubble does nothing: no writes, no memory access, harmless add
  localparam ex_ctrl_t EX_CTRL_BUBBLE = '{
    valid:      1'b0,
    reg_write:  1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    mem_to_reg: 1'b0,
    alu_src:    1'b0,
    illegal:    1'b0,
    alu_sel:    ALU_ADD
  };

endpackage

// File: rtl/alu_control.sv
// ALU control decoder: maps ALUOp and funct to the 4-bit ALU selection code
// and flags R-type funct values the ALU does not implement.
module alu_control
  import mips_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_sel,
  output logic       illegal
);

  // Decode ALUOp first; only R-type consults funct
  always_comb begin
    alu_sel = ALU_ADD;
    illegal = 1'b0;
    unique case (alu_op)
      ALUOP_ADD: alu_sel = ALU_ADD;
      ALUOP_SUB: alu_sel = ALU_SUB;
      ALUOP_OR:  alu_sel = ALU_OR;
      default: begin
        case (funct)
          FUNCT_ADD: alu_sel = ALU_ADD;
          FUNCT_SUB: alu_sel = ALU_SUB;
          FUNCT_AND: alu_sel = ALU_AND;
          FUNCT_OR:  alu_sel = ALU_OR;
          FUNCT_SLT: alu_sel = ALU_SLT;
          default: begin
            alu_sel = ALU_ADD;
            illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands and control, resolves
// EX/MEM and MEM/WB forwarding for the ALU operands, and inserts a bubble on
// a load-use hazard (upstream IF/ID holds on the same signal).
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [1:0]        id_aluOp,
  input  logic [5:0]        id_funct,
  input  logic              id_aluSrc,
  input  logic              id_regDst,
  input  logic              id_regWrite,
  input  logic              id_memRead,
  input  logic              id_memWrite,
  input  logic              id_memToReg,
  input  logic [DATA_W-1:0] id_readData1,
  input  logic [DATA_W-1:0] id_readData2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              exmem_regWrite,
  input  logic              memwb_regWrite,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic [REG_W-1:0]  memwb_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              loadUseHazard,
  output logic              ex_valid,
  output logic [DATA_W-1:0] input1,
  output logic [DATA_W-1:0] input2,
  output logic [3:0]        selectionLines,
  output logic [DATA_W-1:0] ex_storeData,
  output logic [REG_W-1:0]  ex_writeReg,
  output logic              ex_regWrite,
  output logic              ex_memRead,
  output logic              ex_memWrite,
  output logic              ex_memToReg,
  output logic              ex_illegal
);

  ex_ctrl_t          ctrl_q, ctrl_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [REG_W-1:0]  rs_q, rs_d;
  logic [REG_W-1:0]  rt_q, rt_d;
  logic [REG_W-1:0]  wreg_q, wreg_d;

  logic [3:0]        id_alu_sel;
  logic              id_illegal;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;

  alu_control u_alu_control (
    .alu_op  (id_aluOp),
    .funct   (id_funct),
    .alu_sel (id_alu_sel),
    .illegal (id_illegal)
  );

  // Load in EX whose destination is read by the instruction in ID
  always_comb begin
    loadUseHazard = ctrl_q.valid && ctrl_q.mem_read && (wreg_q != '0) &&
                    id_valid && ((wreg_q == id_rs) || (wreg_q == id_rt));
  end

  // Next entry: hold on stall, bubble on flush/hazard/empty ID, else capture
  always_comb begin
    ctrl_d = ctrl_q;
    rd1_d  = rd1_q;
    rd2_d  = rd2_q;
    imm_d  = imm_q;
    rs_d   = rs_q;
    rt_d   = rt_q;
    wreg_d = wreg_q;
    if (!stall) begin
      if (flush || loadUseHazard || !id_valid) begin
        ctrl_d = EX_CTRL_BUBBLE;
        rd1_d  = '0;
        rd2_d  = '0;
        imm_d  = '0;
        rs_d   = '0;
        rt_d   = '0;
        wreg_d = '0;
      end else begin
        ctrl_d.valid      = 1'b1;
        // an unimplemented funct must never commit a register write
        ctrl_d.reg_write  = id_regWrite && !id_illegal;
        ctrl_d.mem_read   = id_memRead;
        ctrl_d.mem_write  = id_memWrite;
        ctrl_d.mem_to_reg = id_memToReg;
        ctrl_d.alu_src    = id_aluSrc;
        ctrl_d.illegal    = id_illegal;
        ctrl_d.alu_sel    = id_alu_sel;
        rd1_d  = id_readData1;
        rd2_d  = id_readData2;
        imm_d  = id_imm;
        rs_d   = id_rs;
        rt_d   = id_rt;
        wreg_d = id_regDst ? id_rd : id_rt;
      end
    end
  end

  // Pipeline register with synchronous reset to a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= EX_CTRL_BUBBLE;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      wreg_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      imm_q  <= imm_d;
      rs_q   <= rs_d;
      rt_q   <= rt_d;
      wreg_q <= wreg_d;
    end
  end

  // Operand forwarding; the younger EX/MEM result beats MEM/WB, $0 never forwards
  always_comb begin
    if (exmem_regWrite && (exmem_rd != '0) && (exmem_rd == rs_q))
      fwd_a = exmem_result;
    else if (memwb_regWrite && (memwb_rd != '0) && (memwb_rd == rs_q))
      fwd_a = memwb_result;
    else
      fwd_a = rd1_q;

    if (exmem_regWrite && (exmem_rd != '0) && (exmem_rd == rt_q))
      fwd_b = exmem_result;
    else if (memwb_regWrite && (memwb_rd != '0) && (memwb_rd == rt_q))
      fwd_b = memwb_result;
    else
      fwd_b = rd2_q;
  end

  assign input1         = fwd_a;
  assign input2         = ctrl_q.alu_src ? imm_q : fwd_b;
  assign ex_storeData   = fwd_b;
  assign selectionLines = ctrl_q.alu_sel;
  assign ex_valid       = ctrl_q.valid;
  assign ex_writeReg    = wreg_q;
  assign ex_regWrite    = ctrl_q.reg_write;
  assign ex_memRead     = ctrl_q.mem_read;
  assign ex_memWrite    = ctrl_q.mem_write;
  assign ex_memToReg    = ctrl_q.mem_to_reg;
  assign ex_illegal     = ctrl_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected EX entries are queued when the ID
// stimulus is driven and popped/compared once the entry reaches EX.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        id_valid;
  logic [1:0]  id_aluOp;
  logic [5:0]  id_funct;
  logic        id_aluSrc, id_regDst, id_regWrite, id_memRead, id_memWrite, id_memToReg;
  logic [31:0] id_readData1, id_readData2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        exmem_regWrite, memwb_regWrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        loadUseHazard, ex_valid;
  logic [31:0] input1, input2, ex_storeData;
  logic [3:0]  selectionLines;
  logic [4:0]  ex_writeReg;
  logic        ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_illegal;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        v;
    logic [3:0]  sel;
    logic        ill, rw, mr, mw, mtr;
    logic [4:0]  wr;
    logic [31:0] in1, in2, st;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_aluOp(id_aluOp), .id_funct(id_funct),
    .id_aluSrc(id_aluSrc), .id_regDst(id_regDst), .id_regWrite(id_regWrite),
    .id_memRead(id_memRead), .id_memWrite(id_memWrite), .id_memToReg(id_memToReg),
    .id_readData1(id_readData1), .id_readData2(id_readData2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .exmem_regWrite(exmem_regWrite), .memwb_regWrite(memwb_regWrite),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_result(exmem_result), .memwb_result(memwb_result),
    .loadUseHazard(loadUseHazard), .ex_valid(ex_valid),
    .input1(input1), .input2(input2), .selectionLines(selectionLines),
    .ex_storeData(ex_storeData), .ex_writeReg(ex_writeReg),
    .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
    .ex_memToReg(ex_memToReg), .ex_illegal(ex_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_id(input logic [1:0] op, input logic [5:0] fn, input logic src,
                        input logic dst, input logic rw, input logic mr, input logic mw,
                        input logic mtr, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] im, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd);
    id_valid = 1'b1; id_aluOp = op; id_funct = fn; id_aluSrc = src; id_regDst = dst;
    id_regWrite = rw; id_memRead = mr; id_memWrite = mw; id_memToReg = mtr;
    id_readData1 = d1; id_readData2 = d2; id_imm = im; id_rs = rs; id_rt = rt; id_rd = rd;
  endtask

  task automatic clr_fwd();
    exmem_regWrite = 1'b0; memwb_regWrite = 1'b0; exmem_rd = 5'd0; memwb_rd = 5'd0;
    exmem_result = 32'h0; memwb_result = 32'h0;
  endtask

  task automatic push_exp(input logic v, input logic [3:0] sel, input logic ill,
                          input logic rw, input logic mr, input logic mw, input logic mtr,
                          input logic [4:0] wr, input logic [31:0] in1,
                          input logic [31:0] in2, input logic [31:0] st);
    exp_t e;
    e.v = v; e.sel = sel; e.ill = ill; e.rw = rw; e.mr = mr; e.mw = mw; e.mtr = mtr;
    e.wr = wr; e.in1 = in1; e.in2 = in2; e.st = st;
    sb.push_back(e);
  endtask

  task automatic push_bubble();
    push_exp(1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=empty-scoreboard expected=entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".valid"},   {31'h0, ex_valid},       {31'h0, e.v});
    chk({tag, ".sel"},     {28'h0, selectionLines}, {28'h0, e.sel});
    chk({tag, ".illegal"}, {31'h0, ex_illegal},     {31'h0, e.ill});
    chk({tag, ".regWr"},   {31'h0, ex_regWrite},    {31'h0, e.rw});
    chk({tag, ".memRd"},   {31'h0, ex_memRead},     {31'h0, e.mr});
    chk({tag, ".memWr"},   {31'h0, ex_memWrite},    {31'h0, e.mw});
    chk({tag, ".memToReg"},{31'h0, ex_memToReg},    {31'h0, e.mtr});
    chk({tag, ".wreg"},    {27'h0, ex_writeReg},    {27'h0, e.wr});
    chk({tag, ".in1"},     input1,                  e.in1);
    chk({tag, ".in2"},     input2,                  e.in2);
    chk({tag, ".store"},   ex_storeData,            e.st);
    $display("txn %s: valid=%0d sel=%b wreg=%0d in1=%0h in2=%0h store=%0h",
             tag, ex_valid, selectionLines, ex_writeReg, input1, input2, ex_storeData);
  endtask

  logic [5:0] fn_tab  [3] = '{6'b100100, 6'b100101, 6'b101010};
  logic [3:0] sel_tab [3] = '{4'b0000, 4'b0001, 4'b0111};

  initial begin
    // reset held two cycles with random ID and forwarding inputs
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    set_id(2'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
           5'($urandom), 5'($urandom), 5'($urandom));
    exmem_regWrite = 1'b1; memwb_regWrite = 1'b1;
    exmem_rd = 5'd7; memwb_rd = 5'd9; exmem_result = $urandom; memwb_result = $urandom;
    tick();
    tick();
    push_bubble();
    check_out("reset");
    chk("reset.hazard", {31'h0, loadUseHazard}, 32'h0);
    reset = 1'b0;
    clr_fwd();

    // R-type sub, no forwarding
    set_id(2'b10, 6'b100010, 0, 1, 1, 0, 0, 0, 32'd10, 32'd4, 32'h0, 5'd2, 5'd3, 5'd9);
    push_exp(1, 4'b0110, 0, 1, 0, 0, 0, 5'd9, 32'd10, 32'd4, 32'd4);
    tick();
    check_out("rsub");

    // unimplemented funct: illegal, write suppressed
    set_id(2'b10, 6'b000000, 0, 1, 1, 0, 0, 0, 32'd10, 32'd4, 32'h0, 5'd2, 5'd3, 5'd9);
    push_exp(1, 4'b0010, 1, 0, 0, 0, 0, 5'd9, 32'd10, 32'd4, 32'd4);
    tick();
    check_out("illegal");

    // remaining R-type functs
    for (int i = 0; i < 3; i++) begin
      set_id(2'b10, fn_tab[i], 0, 1, 1, 0, 0, 0, 32'd20 + i, 32'd30, 32'h0, 5'd2, 5'd3, 5'd11);
      push_exp(1, sel_tab[i], 0, 1, 0, 0, 0, 5'd11, 32'd20 + i, 32'd30, 32'd30);
      tick();
      check_out($sformatf("rfunct%0d", i));
    end

    // ori: aluOp 11 with immediate
    set_id(2'b11, 6'b000000, 1, 0, 1, 0, 0, 0, 32'h5, 32'h6, 32'hF0, 5'd2, 5'd13, 5'd0);
    push_exp(1, 4'b0001, 0, 1, 0, 0, 0, 5'd13, 32'h5, 32'hF0, 32'h6);
    tick();
    check_out("ori");

    // forwarding on rs=5
    set_id(2'b10, 6'b100000, 0, 1, 1, 0, 0, 0, 32'h55, 32'h66, 32'h0, 5'd5, 5'd6, 5'd7);
    tick();
    exmem_regWrite = 1; exmem_rd = 5'd5; exmem_result = 32'h11;
    memwb_regWrite = 1; memwb_rd = 5'd5; memwb_result = 32'h22;
    #1;
    push_exp(1, 4'b0010, 0, 1, 0, 0, 0, 5'd7, 32'h11, 32'h66, 32'h66);
    check_out("fwd_exmem");
    exmem_regWrite = 0;
    #1;
    push_exp(1, 4'b0010, 0, 1, 0, 0, 0, 5'd7, 32'h22, 32'h66, 32'h66);
    check_out("fwd_memwb");
    exmem_regWrite = 1; exmem_rd = 5'd0; memwb_rd = 5'd0;
    #1;
    push_exp(1, 4'b0010, 0, 1, 0, 0, 0, 5'd7, 32'h55, 32'h66, 32'h66);
    check_out("fwd_reg0");
    clr_fwd();

    // load-use: lw $8, then add reading $8
    set_id(2'b00, 6'b000000, 1, 0, 1, 1, 0, 1, 32'h100, 32'h0, 32'h8, 5'd1, 5'd8, 5'd0);
    push_exp(1, 4'b0010, 0, 1, 1, 0, 1, 5'd8, 32'h100, 32'h8, 32'h0);
    tick();
    check_out("lw");
    set_id(2'b10, 6'b100000, 0, 1, 1, 0, 0, 0, 32'd3, 32'h99, 32'h0, 5'd4, 5'd8, 5'd10);
    #1;
    chk("lu.hazard_on", {31'h0, loadUseHazard}, 32'h1);
    push_bubble();
    tick();
    check_out("lu_bubble");
    chk("lu.hazard_off", {31'h0, loadUseHazard}, 32'h0);
    push_exp(1, 4'b0010, 0, 1, 0, 0, 0, 5'd10, 32'd3, 32'h99, 32'h99);
    tick();
    check_out("lu_add");

    // stall three cycles with changing ID: EX frozen
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(2'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), 1, 0, 1, 0,
             $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom));
      push_exp(1, 4'b0010, 0, 1, 0, 0, 0, 5'd10, 32'd3, 32'h99, 32'h99);
      tick();
      check_out($sformatf("stall%0d", i));
    end
    // stall and flush together: still hold
    flush = 1'b1;
    push_exp(1, 4'b0010, 0, 1, 0, 0, 0, 5'd10, 32'd3, 32'h99, 32'h99);
    tick();
    check_out("stall_flush");
    // flush alone: bubble
    stall = 1'b0;
    push_bubble();
    tick();
    check_out("flush");
    flush = 1'b0;

    // sw with rt forwarded from MEM/WB, then overridden by EX/MEM
    set_id(2'b00, 6'b000000, 1, 0, 0, 0, 1, 0, 32'h40, 32'h1, 32'h4, 5'd2, 5'd12, 5'd0);
    tick();
    memwb_regWrite = 1; memwb_rd = 5'd12; memwb_result = 32'hABCD;
    #1;
    push_exp(1, 4'b0010, 0, 0, 0, 1, 0, 5'd12, 32'h40, 32'h4, 32'hABCD);
    check_out("sw_memwb");
    exmem_regWrite = 1; exmem_rd = 5'd12; exmem_result = 32'h77;
    #1;
    push_exp(1, 4'b0010, 0, 0, 0, 1, 0, 5'd12, 32'h40, 32'h4, 32'h77);
    check_out("sw_exmem");
    clr_fwd();

    // reset during stall with a pending load-use hazard
    set_id(2'b00, 6'b000000, 1, 0, 1, 1, 0, 1, 32'h200, 32'h0, 32'h4, 5'd1, 5'd9, 5'd0);
    tick();
    set_id(2'b10, 6'b100000, 0, 1, 1, 0, 0, 0, 32'd1, 32'd2, 32'h0, 5'd9, 5'd3, 5'd14);
    #1;
    chk("rst.hazard_on", {31'h0, loadUseHazard}, 32'h1);
    reset = 1'b1; stall = 1'b1;
    push_bubble();
    tick();
    check_out("rst_mid");
    reset = 1'b0; stall = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
